// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit -- command-side driver for the 8-bit ALU.
//
// Takes one command at a time over a valid/ready handshake. It runs the command
// through the internal ALU against accumulator W. It then commits the result
// into W and a 3-bit status register.
// Each command takes three cycles: IDLE (accept), EXEC (commit), DONE (pulse).
//
// Ports (top, alu_exec_unit):
//   i_clk         clock, every state change on the rising edge
//   i_rst         synchronous reset, active-high, wins over everything
//   i_cmd_valid   command present
//   o_cmd_ready   unit accepts a command this cycle (IDLE only)
//   i_cmd_load    1: LOAD W from i_cmd_oper, 0: ALU op i_cmd_opcode
//   i_cmd_opcode  ALU opcode, one of the `ZEROW..`SHFRW encodings
//   i_cmd_oper    operand P (ALU i_oper2) or LOAD value
//   o_w           accumulator W (ALU i_oper1)
//   o_status      [0] zero, [1] negative, [2] carry out
//   o_done        one-cycle pulse, command committed
//   o_err         one-cycle pulse with o_done, illegal opcode
//
// Ports (alu8, combinational):
//   i_opcode, i_oper1, i_oper2 -> o_result, o_status, o_legal
// -----------------------------------------------------------------------------

`ifndef ALU_OPCODES_DEFINED
`define ALU_OPCODES_DEFINED
`define ZEROW 4'h0  // W <= 0
`define ADDWP 4'h1  // W <= W + P, carry = bit 8 of the sum
`define SUBWP 4'h2  // W <= W - P
`define INCRW 4'h3  // W <= W + 1
`define DECRW 4'h4  // W <= W - 1
`define ANDWP 4'h5  // W <= W & P
`define ORWP  4'h6  // W <= W | P
`define XORWP 4'h7  // W <= W ^ P
`define NOTW  4'h8  // W <= ~W
`define CMPWP 4'h9  // status <= flags of W - P, W unchanged
`define MOVPW 4'hA  // W <= P
`define SHFLW 4'hB  // W <= W << 1, carry = old W[7]
`define SHFRW 4'hC  // W <= W >> 1, carry = old W[0]
`endif

// 8-bit ALU.
// Only ADDWP and the two shifts produce a carry. The subtract, compare and
// increment/decrement ops report Z/N only and leave bit 8 at 0. So a
// wrap-around such as INCRW from 8'hFF gives status 3'b001.
module alu8 (
    input  logic [3:0] i_opcode,
    input  logic [7:0] i_oper1,
    input  logic [7:0] i_oper2,
    output logic [7:0] o_result,
    output logic [2:0] o_status,
    output logic       o_legal
);
    logic [8:0] res9;

    always_comb begin
        res9    = 9'd0;
        o_legal = 1'b1;
        case (i_opcode)
            `ZEROW:         res9 = 9'd0;
            `ADDWP:         res9 = {1'b0, i_oper1} + {1'b0, i_oper2};
            `SUBWP, `CMPWP: res9 = {1'b0, i_oper1 - i_oper2};
            `INCRW:         res9 = {1'b0, i_oper1 + 8'd1};
            `DECRW:         res9 = {1'b0, i_oper1 - 8'd1};
            `ANDWP:         res9 = {1'b0, i_oper1 & i_oper2};
            `ORWP:          res9 = {1'b0, i_oper1 | i_oper2};
            `XORWP:         res9 = {1'b0, i_oper1 ^ i_oper2};
            `NOTW:          res9 = {1'b0, ~i_oper1};
            `MOVPW:         res9 = {1'b0, i_oper2};
            `SHFLW:         res9 = {i_oper1, 1'b0};
            `SHFRW:         res9 = {i_oper1[0], 1'b0, i_oper1[7:1]};
            default:        o_legal = 1'b0;
        endcase
    end

    assign o_result = res9[7:0];
    assign o_status = {res9[8], res9[7], (res9[7:0] == 8'd0)};
endmodule

module alu_exec_unit #(
    parameter logic [7:0] W_RESET   = 8'h00,
    parameter bit         STAT_LOAD = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_load,
    input  logic [3:0] i_cmd_opcode,
    input  logic [7:0] i_cmd_oper,
    output logic [7:0] o_w,
    output logic [2:0] o_status,
    output logic       o_done,
    output logic       o_err
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic       load_q;
    logic [3:0] opcode_q;
    logic [7:0] oper_q;
    logic [7:0] w_q, w_d;
    logic [2:0] status_q, status_d;
    logic       err_d;
    logic       ready_q, done_q, err_q;

    logic [7:0] alu_result;
    logic [2:0] alu_status;
    logic       alu_legal;

    // The ALU sees only registered values. No path runs from i_cmd_* to any output.
    alu8 u_alu (
        .i_opcode (opcode_q),
        .i_oper1  (w_q),
        .i_oper2  (oper_q),
        .o_result (alu_result),
        .o_status (alu_status),
        .o_legal  (alu_legal)
    );

    // Commit values. They are only used on the edge that ends EXEC.
    always_comb begin
        w_d      = w_q;
        status_d = status_q;
        err_d    = 1'b0;
        if (load_q) begin
            w_d = oper_q;
            if (STAT_LOAD)
                status_d = {1'b0, oper_q[7], (oper_q == 8'd0)};
        end else if (!alu_legal) begin
            err_d = 1'b1;
        end else if (opcode_q == `CMPWP) begin
            status_d = alu_status;
        end else begin
            w_d      = alu_result;
            status_d = alu_status;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            load_q   <= 1'b0;
            opcode_q <= 4'd0;
            oper_q   <= 8'd0;
            w_q      <= W_RESET;
            status_q <= 3'b000;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (i_cmd_valid && ready_q) begin
                        load_q   <= i_cmd_load;
                        opcode_q <= i_cmd_opcode;
                        oper_q   <= i_cmd_oper;
                        ready_q  <= 1'b0;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_q      <= w_d;
                    status_q <= status_d;
                    done_q   <= 1'b1;
                    err_q    <= err_d;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    // ready rises only now. A held i_cmd_valid is therefore taken
                    // again one edge later, not on this one.
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = ready_q;
    assign o_w         = w_q;
    assign o_status    = status_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit. The driver pushes the expected
// {W, status, err} for each command it issues. A monitor pops one entry on
// every o_done pulse and compares it.
module tb_alu_exec_unit;
    localparam logic [3:0] OP_ZEROW = 4'h0, OP_ADDWP = 4'h1, OP_SUBWP = 4'h2,
                           OP_INCRW = 4'h3, OP_DECRW = 4'h4, OP_ANDWP = 4'h5,
                           OP_ORWP  = 4'h6, OP_XORWP = 4'h7, OP_NOTW  = 4'h8,
                           OP_CMPWP = 4'h9, OP_MOVPW = 4'hA, OP_SHFLW = 4'hB,
                           OP_SHFRW = 4'hC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [3:0] cmd_opcode = 4'd0;
    logic [7:0] cmd_oper = 8'd0;
    logic [7:0] w;
    logic [2:0] status;
    logic       done;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;

    typedef struct packed {
        logic [7:0] w;
        logic [2:0] st;
        logic       err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.W_RESET(8'h00), .STAT_LOAD(1'b1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_load   (cmd_load),
        .i_cmd_opcode (cmd_opcode),
        .i_cmd_oper   (cmd_oper),
        .o_w          (w),
        .o_status     (status),
        .o_done       (done),
        .o_err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the scoreboard side
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            exp_t e;
            n_done++;
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1 with w=0x%0h st=%b, required no pending command", w, status);
            end else begin
                e = sb.pop_front();
                $display("txn %0d: w=0x%0h st=%b err=%b (exp w=0x%0h st=%b err=%b)",
                         n_done, w, status, err, e.w, e.st, e.err);
                chk("sb_w", {24'd0, w}, {24'd0, e.w});
                chk("sb_status", {29'd0, status}, {29'd0, e.st});
                chk("sb_err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    // Called at a negedge while the unit is IDLE. It drives a single command and
    // checks handshake timing, and it returns at the negedge where the unit is
    // IDLE again.
    task automatic issue(input bit ld, input logic [3:0] op, input logic [7:0] p,
                         input logic [7:0] ew, input logic [2:0] es, input bit ee);
        exp_t e;
        chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_load   = ld;
        cmd_opcode = op;
        cmd_oper   = p;
        e.w = ew; e.st = es; e.err = ee;
        sb.push_back(e);
        @(negedge clk);                       // EXEC
        cmd_valid  = 1'b0;
        cmd_load   = 1'b0;                    // garbage after accept must be ignored
        cmd_opcode = 4'hE;
        cmd_oper   = 8'hA5;
        chk("exec_done_low", {31'd0, done}, 32'd0);
        chk("exec_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);                       // DONE: accept edge + 2
        chk("latency_done", {31'd0, done}, 32'd1);
        chk("done_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);                       // IDLE
        chk("idle_done_low", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        int done_base;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_w", {24'd0, w}, 32'h00);
        chk("reset_status", {29'd0, status}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);

        // 1: LOAD 200, ADD 100 -> 44 with carry
        issue(1, 4'd0,     8'd200, 8'd200, 3'b010, 0);
        issue(0, OP_ADDWP, 8'd100, 8'd44,  3'b100, 0);
        // 2: compare below and equal
        issue(1, 4'd0,     8'd80, 8'd80, 3'b000, 0);
        issue(0, OP_CMPWP, 8'd90, 8'd80, 3'b010, 0);
        issue(0, OP_CMPWP, 8'd80, 8'd80, 3'b001, 0);

        // 3: INCRW with valid held for 8 cycles from W=255
        issue(1, 4'd0, 8'd255, 8'd255, 3'b010, 0);
        sb.push_back('{w: 8'd0, st: 3'b001, err: 1'b0});
        sb.push_back('{w: 8'd1, st: 3'b000, err: 1'b0});
        sb.push_back('{w: 8'd2, st: 3'b000, err: 1'b0});
        done_base  = n_done;
        rdy_cnt    = 0;
        cmd_valid  = 1'b1;
        cmd_load   = 1'b0;
        cmd_opcode = OP_INCRW;
        cmd_oper   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (cmd_ready) rdy_cnt++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_ready_cycles", rdy_cnt, 32'd3);
        chk("hold_commits", n_done - done_base, 32'd3);
        chk("hold_final_w", {24'd0, w}, 32'd2);

        // 4: illegal opcodes keep W and status
        issue(1, 4'd0,     8'h5A, 8'h5A, 3'b000, 0);
        issue(0, OP_CMPWP, 8'h5A, 8'h5A, 3'b001, 0);
        issue(0, 4'hF,     8'h11, 8'h5A, 3'b001, 1);
        issue(0, 4'hD,     8'h22, 8'h5A, 3'b001, 1);

        // 5: reset during EXEC discards the command
        issue(1, 4'd0, 8'h33, 8'h33, 3'b000, 0);
        done_base  = n_done;
        cmd_valid  = 1'b1;
        cmd_opcode = OP_SUBWP;
        cmd_oper   = 8'h01;
        @(negedge clk);                       // EXEC
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_w", {24'd0, w}, 32'h00);
        chk("rst_exec_status", {29'd0, status}, 32'd0);
        chk("rst_exec_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_exec_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_exec_no_done", n_done - done_base, 32'd0);

        // 6: LOAD status and the remaining ops
        issue(1, 4'd0,     8'h80, 8'h80, 3'b010, 0);
        issue(1, 4'd0,     8'h00, 8'h00, 3'b001, 0);
        issue(1, 4'd0,     8'h0F, 8'h0F, 3'b000, 0);
        issue(0, OP_XORWP, 8'hFF, 8'hF0, 3'b010, 0);
        issue(0, OP_SHFLW, 8'h00, 8'hE0, 3'b110, 0);
        issue(0, OP_SHFRW, 8'h00, 8'h70, 3'b000, 0);
        issue(0, OP_DECRW, 8'h00, 8'h6F, 3'b000, 0);
        issue(0, OP_ANDWP, 8'h0F, 8'h0F, 3'b000, 0);
        issue(0, OP_ORWP,  8'hF0, 8'hFF, 3'b010, 0);
        issue(0, OP_NOTW,  8'h00, 8'h00, 3'b001, 0);
        issue(0, OP_MOVPW, 8'h7F, 8'h7F, 3'b000, 0);
        issue(0, OP_SUBWP, 8'h80, 8'hFF, 3'b010, 0);
        issue(0, OP_ZEROW, 8'h12, 8'h00, 3'b001, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
